// File: rtl/i2c_target.sv
// I2C register target: 8 x 8-bit registers behind an auto-incrementing 3-bit pointer.
// SCL/SDA are synchronized and glitch-filtered; SDA is driven open-drain via sda_oe.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int          FILTER   = 3
) (
    input  logic       clk_p,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [2:0] loc_addr,
    input  logic       loc_we,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       bus_wr,
    output logic [2:0] bus_wr_addr,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WACK, RDATA, RACK, WAIT_STOP
    } state_t;

    localparam int            CW   = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FILTER - 1);

    logic [1:0]    r_scl_s, r_sda_s;
    logic [CW-1:0] r_scl_cnt, r_sda_cnt;
    logic          r_scl_f, r_sda_f, r_scl_q, r_sda_q;

    state_t     r_state, w_state_n;
    logic [2:0] r_bitcnt, w_bitcnt_n;
    logic [2:0] r_ptr, w_ptr_n;
    logic [7:0] r_shift, w_shift_n;
    logic       r_sda_oe, w_oe_n;
    logic       r_busy, w_busy_n;
    logic       r_bus_wr, w_bus_we;
    logic [2:0] r_bus_wr_addr;
    logic [7:0] r_loc_rdata;
    logic [7:0] r_regs [8];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte, w_rd_byte;

    // A new level is accepted only after FILTER consecutive differing samples
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s   <= 2'b11;
            r_sda_s   <= 2'b11;
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_q   <= 1'b1;
            r_sda_q   <= 1'b1;
        end else begin
            r_scl_s <= {r_scl_s[0], scl_i};
            r_sda_s <= {r_sda_s[0], sda_i};
            r_scl_q <= r_scl_f;
            r_sda_q <= r_sda_f;
            if (r_scl_s[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == CMAX) begin
                r_scl_f   <= r_scl_s[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end
            if (r_sda_s[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == CMAX) begin
                r_sda_f   <= r_sda_s[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_q;
    assign w_scl_fall = ~r_scl_f & r_scl_q;
    assign w_start    = r_scl_f & r_scl_q & r_sda_q & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_q & ~r_sda_q & r_sda_f;
    assign w_byte     = {r_shift[6:0], r_sda_f};
    assign w_rd_byte  = r_regs[r_ptr];

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_bitcnt      <= '0;
            r_ptr         <= '0;
            r_shift       <= '0;
            r_sda_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_bus_wr      <= 1'b0;
            r_bus_wr_addr <= '0;
        end else begin
            r_state  <= w_state_n;
            r_bitcnt <= w_bitcnt_n;
            r_ptr    <= w_ptr_n;
            r_shift  <= w_shift_n;
            r_sda_oe <= w_oe_n;
            r_busy   <= w_busy_n;
            r_bus_wr <= w_bus_we;
            if (w_bus_we) r_bus_wr_addr <= r_ptr;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_bitcnt_n = r_bitcnt;
        w_ptr_n    = r_ptr;
        w_shift_n  = r_shift;
        w_oe_n     = r_sda_oe;
        w_busy_n   = r_busy;
        w_bus_we   = 1'b0;
        if (w_stop) begin
            w_state_n = IDLE;
            w_oe_n    = 1'b0;
            w_busy_n  = 1'b0;
        end else if (w_start) begin
            w_state_n  = ADDR;
            w_bitcnt_n = '0;
            w_oe_n     = 1'b0;
        end else begin
            unique case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift_n  = w_byte;
                    w_bitcnt_n = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_busy_n  = (w_byte[7:1] == DEV_ADDR);
                        w_state_n = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                PTR: if (w_scl_rise) begin
                    w_shift_n  = w_byte;
                    w_bitcnt_n = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_ptr_n   = w_byte[2:0];
                        w_state_n = PTR_ACK;
                    end
                end
                WDATA: if (w_scl_rise) begin
                    w_shift_n  = w_byte;
                    w_bitcnt_n = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_bus_we  = 1'b1;
                        w_ptr_n   = r_ptr + 3'd1;
                        w_state_n = WACK;
                    end
                end
                // First fall drives the ACK, second fall releases and moves on
                ADDR_ACK, PTR_ACK, WACK: if (w_scl_fall) begin
                    w_oe_n = ~r_sda_oe;
                    if (r_sda_oe) begin
                        if (r_state != ADDR_ACK) begin
                            w_state_n = WDATA;
                        end else if (!r_shift[0]) begin
                            w_state_n = PTR;
                        end else begin
                            w_state_n = RDATA;
                            w_shift_n = w_rd_byte;
                            w_oe_n    = ~w_rd_byte[7];
                        end
                    end
                end
                RDATA: begin
                    if (w_scl_fall) begin
                        if (r_bitcnt == 3'd0) begin
                            w_shift_n = w_rd_byte;
                            w_oe_n    = ~w_rd_byte[7];
                        end else begin
                            w_shift_n = {r_shift[6:0], 1'b0};
                            w_oe_n    = ~r_shift[6];
                        end
                    end else if (w_scl_rise) begin
                        w_bitcnt_n = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) w_state_n = RACK;
                    end
                end
                RACK: begin
                    if (w_scl_fall) begin
                        w_oe_n = 1'b0;
                    end else if (w_scl_rise) begin
                        w_ptr_n = r_ptr + 3'd1;
                        if (r_sda_f) begin
                            w_state_n = WAIT_STOP;
                            w_busy_n  = 1'b0;
                        end else begin
                            w_state_n = RDATA;
                        end
                    end
                end
                IDLE, WAIT_STOP: ;
                default: w_state_n = IDLE;
            endcase
        end
    end

    // A bus write to the same index overrides the local write
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_loc_rdata <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_bus_we && r_ptr == 3'(i)) begin
                    r_regs[i] <= w_byte;
                end else if (loc_we && loc_addr == 3'(i)) begin
                    r_regs[i] <= loc_wdata;
                end
            end
            r_loc_rdata <= r_regs[loc_addr];
        end
    end

    assign sda_oe      = r_sda_oe;
    assign busy        = r_busy;
    assign bus_wr      = r_bus_wr;
    assign bus_wr_addr = r_bus_wr_addr;
    assign loc_rdata   = r_loc_rdata;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, transaction-level register
// model, and monitors popping expected writes/read bytes from queues.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int         Q   = 8;
    localparam logic [6:0] DEV = 7'h50;

    logic       clk_p = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [2:0] loc_addr = '0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_wdata = '0;
    logic [7:0] loc_rdata;
    logic       bus_wr;
    logic [2:0] bus_wr_addr;
    logic       busy;

    assign sda_line = m_sda & ~sda_oe;
    always #5 clk_p = ~clk_p;

    i2c_target #(.DEV_ADDR(DEV), .FILTER(3)) dut (
        .clk_p(clk_p), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_line),
        .sda_oe(sda_oe), .loc_addr(loc_addr), .loc_we(loc_we),
        .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .bus_wr(bus_wr),
        .bus_wr_addr(bus_wr_addr), .busy(busy)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_regs [8];
    logic [2:0] m_ptr;
    logic [2:0] exp_wr_q [$];
    logic [7:0] exp_rd_q [$];
    logic       rd_phase = 1'b0;
    int         rd_bits = 0;
    logic [7:0] rd_sh = '0;
    logic       oe_watch = 1'b0;
    logic       oe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk_p) begin
        if (bus_wr) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_wr_unexpected: got addr %0h expected none", bus_wr_addr);
            end else begin
                check("bus_wr_addr", {29'b0, bus_wr_addr}, {29'b0, exp_wr_q.pop_front()});
            end
        end
        if (oe_watch && sda_oe) oe_seen = 1'b1;
    end

    always @(posedge m_scl) begin
        if (!rd_phase) begin
            rd_bits = 0;
        end else begin
            rd_sh = {rd_sh[6:0], sda_line};
            rd_bits++;
            if (rd_bits == 8) begin
                rd_bits = 0;
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got %0h expected none", rd_sh);
                end else begin
                    check("rd_data", {24'b0, rd_sh}, {24'b0, exp_rd_q.pop_front()});
                end
            end
        end
    end

    task automatic hq();
        repeat (Q) @(negedge clk_p);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hq();
        m_scl = 1'b1; hq();
        m_sda = 1'b0; hq();
        m_scl = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hq();
        m_scl = 1'b1; hq();
        m_sda = 1'b1; hq();
    endtask

    task automatic wbit(input logic b);
        m_sda = b; hq();
        m_scl = 1'b1; hq(); hq();
        m_scl = 1'b0; hq();
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; hq();
        m_scl = 1'b1; hq();
        b = sda_line; hq();
        m_scl = 1'b0; hq();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(input logic nack);
        logic b;
        rd_phase = 1'b1;
        for (int i = 0; i < 8; i++) rbit(b);
        rd_phase = 1'b0;
        wbit(nack);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_ptr = '0;
    endtask

    task automatic loc_read(input logic [2:0] a, input string name);
        @(negedge clk_p);
        loc_addr = a;
        @(negedge clk_p);
        check(name, {24'b0, loc_rdata}, {24'b0, m_regs[a]});
    endtask

    task automatic loc_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk_p);
        loc_addr = a; loc_wdata = d; loc_we = 1'b1;
        @(negedge clk_p);
        loc_we = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] data [$]);
        logic ack;
        i2c_start();
        wbyte({DEV, 1'b0}, ack);
        check("wr_addr_ack", {31'b0, ack}, 0);
        check("busy_addressed", {31'b0, busy}, 1);
        wbyte(p, ack);
        check("wr_ptr_ack", {31'b0, ack}, 0);
        m_ptr = p[2:0];
        foreach (data[i]) begin
            exp_wr_q.push_back(m_ptr);
            m_regs[m_ptr] = data[i];
            m_ptr = m_ptr + 3'd1;
            wbyte(data[i], ack);
            check("wr_data_ack", {31'b0, ack}, 0);
        end
        i2c_stop();
        check("busy_after_stop", {31'b0, busy}, 0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic ack;
        i2c_start();
        if (set_ptr) begin
            wbyte({DEV, 1'b0}, ack);
            check("rd_waddr_ack", {31'b0, ack}, 0);
            wbyte(p, ack);
            check("rd_ptr_ack", {31'b0, ack}, 0);
            m_ptr = p[2:0];
            i2c_start();
        end
        wbyte({DEV, 1'b1}, ack);
        check("rd_addr_ack", {31'b0, ack}, 0);
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back(m_regs[m_ptr]);
            m_ptr = m_ptr + 3'd1;
            rbyte(k == n - 1);
            if (k < n - 1) check("busy_mid_read", {31'b0, busy}, 1);
        end
        check("busy_after_nack", {31'b0, busy}, 0);
        i2c_stop();
    endtask

    task automatic do_conflict();
        logic ack;
        logic seen;
        seen = 1'b0;
        i2c_start();
        wbyte({DEV, 1'b0}, ack);
        check("cf_addr_ack", {31'b0, ack}, 0);
        wbyte(8'h02, ack);
        check("cf_ptr_ack", {31'b0, ack}, 0);
        exp_wr_q.push_back(3'd2);
        m_regs[2] = 8'hC3;
        m_ptr = 3'd3;
        fork
            wbyte(8'hC3, ack);
            begin
                loc_addr = 3'd2; loc_wdata = 8'h5A; loc_we = 1'b1;
                for (int t = 0; t < 2000; t++) begin
                    @(negedge clk_p);
                    if (bus_wr) break;
                end
                seen = bus_wr;
                loc_we = 1'b0;
            end
        join
        check("cf_bus_wr_seen", {31'b0, seen}, 1);
        check("cf_data_ack", {31'b0, ack}, 0);
        i2c_stop();
        loc_read(3'd2, "cf_reg2");
    endtask

    task automatic do_glitch(input logic [7:0] p, input logic [7:0] d1,
                             input logic [7:0] d2);
        logic ack;
        i2c_start();
        wbyte({DEV, 1'b0}, ack);
        check("gl_addr_ack", {31'b0, ack}, 0);
        wbyte(p, ack);
        check("gl_ptr_ack", {31'b0, ack}, 0);
        m_ptr = p[2:0];
        exp_wr_q.push_back(m_ptr);
        m_regs[m_ptr] = d1;
        m_ptr = m_ptr + 3'd1;
        for (int i = 7; i >= 0; i--) begin
            wbit(d1[i]);
            if (i == 5) begin
                @(negedge clk_p) m_scl = 1'b1;
                @(negedge clk_p) m_scl = 1'b0;
                hq();
            end
        end
        rbit(ack);
        check("gl_data_ack", {31'b0, ack}, 0);
        for (int i = 7; i >= 4; i--) wbit(d2[i]);
        i2c_stop();
        check("gl_busy_idle", {31'b0, busy}, 0);
    endtask

    task automatic do_wrong_addr();
        logic ack;
        oe_seen = 1'b0;
        oe_watch = 1'b1;
        i2c_start();
        wbyte(8'hB0, ack);
        check("wa_nack", {31'b0, ack}, 1);
        check("wa_busy", {31'b0, busy}, 0);
        wbyte(8'($urandom), ack);
        i2c_stop();
        oe_watch = 1'b0;
        check("wa_oe_never", {31'b0, oe_seen}, 0);
    endtask

    task automatic do_reset_mid_read();
        logic ack;
        logic b;
        loc_write(3'd4, 8'h00);
        i2c_start();
        wbyte({DEV, 1'b0}, ack);
        wbyte(8'h04, ack);
        i2c_start();
        wbyte({DEV, 1'b1}, ack);
        check("rs_addr_ack", {31'b0, ack}, 0);
        for (int i = 0; i < 3; i++) rbit(b);
        check("rs_driving", {31'b0, sda_oe}, 1);
        @(negedge clk_p);
        rst_n = 1'b0;
        #1;
        check("rs_oe_async", {31'b0, sda_oe}, 0);
        repeat (3) @(negedge clk_p);
        check("rs_busy", {31'b0, busy}, 0);
        check("rs_loc_rdata", {24'b0, loc_rdata}, 0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) wbit(1'($urandom));
        for (int i = 0; i < 8; i++) loc_read(3'(i), "rs_reg_zero");
    endtask

    initial begin
        #950_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q [$];
        model_reset();
        repeat (4) @(negedge clk_p);
        check("rst_sda_oe", {31'b0, sda_oe}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_bus_wr", {31'b0, bus_wr}, 0);
        check("rst_bus_wr_addr", {29'b0, bus_wr_addr}, 0);
        check("rst_loc_rdata", {24'b0, loc_rdata}, 0);
        rst_n = 1'b1;
        hq();

        q = '{8'h11, 8'h22, 8'h33};
        do_write(8'h06, q);
        loc_read(3'd6, "burst_reg6");
        loc_read(3'd7, "burst_reg7");
        loc_read(3'd0, "burst_reg0");

        do_read(1'b1, 8'h07, 2);
        do_wrong_addr();
        do_conflict();
        loc_write(3'd5, 8'h77);
        loc_read(3'd5, "loc_reg5");
        do_glitch(8'h03, 8'($urandom), 8'($urandom));

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                q.delete();
                for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                    q.push_back(8'($urandom));
                do_write(8'($urandom), q);
            end else begin
                do_read(1'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 3) == 0)
                loc_write(3'($urandom), 8'($urandom));
        end

        do_reset_mid_read();
        q = '{8'($urandom), 8'($urandom)};
        do_write(8'h01, q);
        do_read(1'b0, 8'h00, 2);
        do_read(1'b1, 8'h01, 2);

        for (int i = 0; i < 8; i++) loc_read(3'(i), "final_reg");
        check("wr_queue_empty", exp_wr_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
